alu_seq: RTL and testbench

Parametrised successor to the processor's combinational ALU. It registers all results behind a valid/ready handshake and adds MIPS HI/LO multiply and divide, executed iteratively over multiple cycles. It sits in the execute stage between the operand-select muxes and the EX/MEM register. The decode stage stalls issue while `in_ready` is low.

---
 rtl/alu_pkg.sv | 32 +++
 rtl/alu_seq_muldiv.sv | 137 +++++++++++++
 rtl/alu_seq.sv | 188 ++++++++++++++++++
 tb/tb_alu_seq.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared MIPS funct codes and control-state encoding for alu_seq.
package alu_pkg;

    typedef enum logic [5:0] {
        F_SLL   = 6'b000000,
        F_SRL   = 6'b000010,
        F_SRA   = 6'b000011,
        F_MFHI  = 6'b010000,
        F_MFLO  = 6'b010010,
        F_MULT  = 6'b011000,
        F_MULTU = 6'b011001,
        F_DIV   = 6'b011010,
        F_DIVU  = 6'b011011,
        F_ADD   = 6'b100000,
        F_ADDU  = 6'b100001,
        F_SUB   = 6'b100010,
        F_SUBU  = 6'b100011,
        F_AND   = 6'b100100,
        F_OR    = 6'b100101,
        F_XOR   = 6'b100110,
        F_NOR   = 6'b100111,
        F_SLT   = 6'b101010,
        F_SLTU  = 6'b101011
    } alu_func_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DIV  = 2'd2
    } alu_state_e;

endpackage

// File: rtl/alu_seq_muldiv.sv
// Iterative HI/LO engine: shift-add multiply and, with ALU_SEQ_DIVIDE_EN, restoring divide.
// Works on operand magnitudes for DATA_WIDTH steps; the last step applies sign correction and commits.
module alu_seq_muldiv #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  ref_clk,
    input  logic                  reset,
    input  logic                  i_start,
`ifdef ALU_SEQ_DIVIDE_EN
    input  logic                  i_is_div,
`endif
    input  logic                  i_signed,
    input  logic [DATA_WIDTH-1:0] i_a,
    input  logic [DATA_WIDTH-1:0] i_b,
    output logic                  o_done,
    output logic [DATA_WIDTH-1:0] o_done_lo,
    output logic [DATA_WIDTH-1:0] o_hi,
    output logic [DATA_WIDTH-1:0] o_lo
);
    localparam int               CNT_W    = $clog2(DATA_WIDTH) + 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DATA_WIDTH - 1);

    logic                    r_busy;
    logic [CNT_W-1:0]        r_cnt;
    logic [DATA_WIDTH-1:0]   r_acc;
    logic [DATA_WIDTH-1:0]   r_q;
    logic [DATA_WIDTH-1:0]   r_m;
    logic [DATA_WIDTH-1:0]   r_hi;
    logic [DATA_WIDTH-1:0]   r_lo;
    logic                    r_neg_q;

    logic                    w_neg_a;
    logic                    w_neg_b;
    logic [DATA_WIDTH-1:0]   w_mag_a;
    logic [DATA_WIDTH-1:0]   w_mag_b;
    logic [DATA_WIDTH:0]     w_sum;
    logic [DATA_WIDTH-1:0]   w_acc_nxt;
    logic [DATA_WIDTH-1:0]   w_q_nxt;
    logic [2*DATA_WIDTH-1:0] w_prod;
    logic [DATA_WIDTH-1:0]   w_fin_hi;
    logic [DATA_WIDTH-1:0]   w_fin_lo;

`ifdef ALU_SEQ_DIVIDE_EN
    logic                    r_is_div;
    logic                    r_neg_r;
    logic                    r_div0;
    logic [DATA_WIDTH:0]     w_shift;
    logic [DATA_WIDTH:0]     w_diff;
`endif

    assign w_neg_a   = i_signed & i_a[DATA_WIDTH-1];
    assign w_neg_b   = i_signed & i_b[DATA_WIDTH-1];
    assign w_mag_a   = w_neg_a ? -i_a : i_a;
    assign w_mag_b   = w_neg_b ? -i_b : i_b;
    assign o_done    = r_busy && (r_cnt == LAST_CNT);
    assign o_done_lo = w_fin_lo;
    assign o_hi      = r_hi;
    assign o_lo      = r_lo;

    // r_acc is the running high half (partial product or remainder); r_q shifts A out and result bits in.
    always_comb begin
        // NOTE: every signal written here gets a default first, so no path can infer a latch.
        w_sum     = {1'b0, r_acc} + (r_q[0] ? {1'b0, r_m} : '0);
        w_acc_nxt = w_sum[DATA_WIDTH:1];
        w_q_nxt   = {w_sum[0], r_q[DATA_WIDTH-1:1]};
`ifdef ALU_SEQ_DIVIDE_EN
        w_shift   = {r_acc, r_q[DATA_WIDTH-1]};
        w_diff    = w_shift - {1'b0, r_m};
        if (r_is_div) begin
            if (!w_diff[DATA_WIDTH]) begin
                w_acc_nxt = w_diff[DATA_WIDTH-1:0];
                w_q_nxt   = {r_q[DATA_WIDTH-2:0], 1'b1};
            end else begin
                w_acc_nxt = w_shift[DATA_WIDTH-1:0];
                w_q_nxt   = {r_q[DATA_WIDTH-2:0], 1'b0};
            end
        end
`endif
    end

    always_comb begin
        w_prod = {w_acc_nxt, w_q_nxt};
        if (r_neg_q) begin
            w_prod = -w_prod;
        end
        w_fin_hi = w_prod[2*DATA_WIDTH-1:DATA_WIDTH];
        w_fin_lo = w_prod[DATA_WIDTH-1:0];
`ifdef ALU_SEQ_DIVIDE_EN
        // Divide by zero naturally leaves |A| in the remainder; only the quotient needs forcing.
        if (r_is_div) begin
            w_fin_lo = r_div0 ? '1 : (r_neg_q ? -w_q_nxt : w_q_nxt);
            w_fin_hi = r_neg_r ? -w_acc_nxt : w_acc_nxt;
        end
`endif
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge ref_clk or negedge reset) begin
        if (!reset) begin
            r_busy   <= 1'b0;
            r_cnt    <= '0;
            r_acc    <= '0;
            r_q      <= '0;
            r_m      <= '0;
            r_hi     <= '0;
            r_lo     <= '0;
            r_neg_q  <= 1'b0;
`ifdef ALU_SEQ_DIVIDE_EN
            r_is_div <= 1'b0;
            r_neg_r  <= 1'b0;
            r_div0   <= 1'b0;
`endif
        end else if (i_start) begin
            r_busy   <= 1'b1;
            r_cnt    <= '0;
            r_acc    <= '0;
            r_q      <= w_mag_a;
            r_m      <= w_mag_b;
            r_neg_q  <= w_neg_a ^ w_neg_b;
`ifdef ALU_SEQ_DIVIDE_EN
            r_is_div <= i_is_div;
            r_neg_r  <= w_neg_a;
            r_div0   <= (i_b == '0);
`endif
        end else if (r_busy) begin
            r_acc <= w_acc_nxt;
            r_q   <= w_q_nxt;
            r_cnt <= r_cnt + 1'b1;
            if (o_done) begin
                r_busy <= 1'b0;
                r_hi   <= w_fin_hi;
                r_lo   <= w_fin_lo;
            end
        end
    end

endmodule

// File: rtl/alu_seq.sv
// Registered MIPS execute-stage ALU with iterative HI/LO multiply/divide behind valid/ready.
// Define ALU_SEQ_DIVIDE_EN to build the divider; otherwise div/divu respond as illegal.
module alu_seq
    import alu_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  ref_clk,
    input  logic                  reset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [5:0]            Func_in,
    input  logic [DATA_WIDTH-1:0] A_in,
    input  logic [DATA_WIDTH-1:0] B_in,
    output logic                  out_valid,
    output logic [DATA_WIDTH-1:0] O_out,
    output logic                  Branch_out,
    output logic                  ovf_out,
    output logic                  illegal_out
);
    localparam int SHAMT_W = $clog2(DATA_WIDTH);
    localparam int MSB     = DATA_WIDTH - 1;

    alu_state_e            r_state;
    alu_state_e            w_state_nxt;
    alu_func_e             w_func;

    logic                  r_out_valid;
    logic [DATA_WIDTH-1:0] r_o;
    logic                  r_branch;
    logic                  r_ovf;
    logic                  r_illegal;
    logic                  r_eq_pend;

    logic                  w_accept;
    logic                  w_start;
    logic                  w_iter;
    logic                  w_div;
    logic                  w_signed;
    logic                  w_ovf;
    logic                  w_illegal;
    logic                  w_done;
    logic [SHAMT_W-1:0]    w_shamt;
    logic [DATA_WIDTH-1:0] w_add;
    logic [DATA_WIDTH-1:0] w_sub;
    logic [DATA_WIDTH-1:0] w_res;
    logic [DATA_WIDTH-1:0] w_hi;
    logic [DATA_WIDTH-1:0] w_lo;
    logic [DATA_WIDTH-1:0] w_done_lo;

    assign w_func   = alu_func_e'(Func_in);
    assign w_shamt  = A_in[SHAMT_W-1:0];
    assign w_add    = A_in + B_in;
    assign w_sub    = A_in - B_in;
    assign w_accept = in_valid && in_ready;
    assign w_start  = w_accept && w_iter;

    always_comb begin
        w_res     = '0;
        w_ovf     = 1'b0;
        w_illegal = 1'b0;
        w_iter    = 1'b0;
        w_div     = 1'b0;
        w_signed  = 1'b0;
        case (w_func)
            F_ADD: begin
                w_res = w_add;
                w_ovf = (A_in[MSB] == B_in[MSB]) && (w_add[MSB] != A_in[MSB]);
            end
            F_ADDU: w_res = w_add;
            F_SUB: begin
                w_res = w_sub;
                w_ovf = (A_in[MSB] != B_in[MSB]) && (w_sub[MSB] != A_in[MSB]);
            end
            F_SUBU: w_res = w_sub;
            F_AND:  w_res = A_in & B_in;
            F_OR:   w_res = A_in | B_in;
            F_XOR:  w_res = A_in ^ B_in;
            F_NOR:  w_res = ~(A_in | B_in);
            F_SLT:  w_res = {{(DATA_WIDTH-1){1'b0}}, ($signed(A_in) < $signed(B_in))};
            F_SLTU: w_res = {{(DATA_WIDTH-1){1'b0}}, (A_in < B_in)};
            F_SLL:  w_res = B_in << w_shamt;
            F_SRL:  w_res = B_in >> w_shamt;
            F_SRA:  w_res = $unsigned($signed(B_in) >>> w_shamt);
            F_MFHI: w_res = w_hi;
            F_MFLO: w_res = w_lo;
            F_MULT: begin
                w_iter   = 1'b1;
                w_signed = 1'b1;
            end
            F_MULTU: w_iter = 1'b1;
`ifdef ALU_SEQ_DIVIDE_EN
            F_DIV: begin
                w_iter   = 1'b1;
                w_div    = 1'b1;
                w_signed = 1'b1;
            end
            F_DIVU: begin
                w_iter = 1'b1;
                w_div  = 1'b1;
            end
`endif
            default: w_illegal = 1'b1;
        endcase
    end

    always_ff @(posedge ref_clk or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        in_ready    = 1'b0;
        case (r_state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid && w_iter) begin
                    w_state_nxt = w_div ? DIV : MUL;
                end
            end
            MUL, DIV: begin
                if (w_done) begin
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // Result fields change only on an out_valid pulse and hold otherwise.
    always_ff @(posedge ref_clk or negedge reset) begin
        if (!reset) begin
            r_out_valid <= 1'b0;
            r_o         <= '0;
            r_branch    <= 1'b0;
            r_ovf       <= 1'b0;
            r_illegal   <= 1'b0;
            r_eq_pend   <= 1'b0;
        end else begin
            r_out_valid <= 1'b0;
            if (w_accept && !w_iter) begin
                r_out_valid <= 1'b1;
                r_o         <= w_res;
                r_branch    <= (A_in == B_in);
                r_ovf       <= w_ovf;
                r_illegal   <= w_illegal;
            end else if (w_start) begin
                r_eq_pend <= (A_in == B_in);
            end
            if (w_done) begin
                r_out_valid <= 1'b1;
                r_o         <= w_done_lo;
                r_branch    <= r_eq_pend;
                r_ovf       <= 1'b0;
                r_illegal   <= 1'b0;
            end
        end
    end

    assign out_valid   = r_out_valid;
    assign O_out       = r_o;
    assign Branch_out  = r_branch;
    assign ovf_out     = r_ovf;
    assign illegal_out = r_illegal;

    alu_seq_muldiv #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_muldiv (
        .ref_clk   (ref_clk),
        .reset     (reset),
        .i_start   (w_start),
`ifdef ALU_SEQ_DIVIDE_EN
        .i_is_div  (w_div),
`endif
        .i_signed  (w_signed),
        .i_a       (A_in),
        .i_b       (B_in),
        .o_done    (w_done),
        .o_done_lo (w_done_lo),
        .o_hi      (w_hi),
        .o_lo      (w_lo)
    );

endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq (DATA_WIDTH=32): directed vectors, an arithmetic reference model
// with a per-cycle compare process, and literal expectations. Honours ALU_SEQ_DIVIDE_EN.
module tb_alu_seq;
    localparam int W = 32;

    localparam logic [5:0] OP_SLL = 6'b000000, OP_SRL = 6'b000010, OP_SRA = 6'b000011;
    localparam logic [5:0] OP_MFHI = 6'b010000, OP_MFLO = 6'b010010;
    localparam logic [5:0] OP_MULT = 6'b011000, OP_MULTU = 6'b011001;
    localparam logic [5:0] OP_DIV = 6'b011010, OP_DIVU = 6'b011011;
    localparam logic [5:0] OP_ADD = 6'b100000, OP_ADDU = 6'b100001;
    localparam logic [5:0] OP_SUB = 6'b100010, OP_SUBU = 6'b100011;
    localparam logic [5:0] OP_AND = 6'b100100, OP_OR = 6'b100101;
    localparam logic [5:0] OP_XOR = 6'b100110, OP_NOR = 6'b100111;
    localparam logic [5:0] OP_SLT = 6'b101010, OP_SLTU = 6'b101011;
    localparam longint SMAX = 2147483647;
    localparam longint SMIN = -SMAX - 1;

    logic         ref_clk;
    logic         reset;
    logic         in_valid;
    logic         in_ready;
    logic [5:0]   Func_in;
    logic [W-1:0] A_in;
    logic [W-1:0] B_in;
    logic         out_valid;
    logic [W-1:0] O_out;
    logic         Branch_out;
    logic         ovf_out;
    logic         illegal_out;

    alu_seq #(.DATA_WIDTH(W)) dut (
        .ref_clk     (ref_clk),
        .reset       (reset),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .Func_in     (Func_in),
        .A_in        (A_in),
        .B_in        (B_in),
        .out_valid   (out_valid),
        .O_out       (O_out),
        .Branch_out  (Branch_out),
        .ovf_out     (ovf_out),
        .illegal_out (illegal_out)
    );

    typedef struct {
        logic [W-1:0] o;
        logic         br;
        logic         ovf;
        logic         ill;
        int           due;
        bit           has_lit;
        logic [W-1:0] lit_o;
        logic         lit_br;
        logic         lit_ovf;
        logic         lit_ill;
    } exp_t;

    exp_t         q[$];
    exp_t         ce;
    logic [W-1:0] m_hi = '0;
    logic [W-1:0] m_lo = '0;
    int           busy_lo = 1;
    int           busy_hi = 0;
    int           cyc = 0;
    int           n_checks = 0;
    int           n_fail = 0;

    initial ref_clk = 1'b0;
    always #5 ref_clk = ~ref_clk;
    always @(posedge ref_clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic wait_neg();
        @(negedge ref_clk);
        #1;
    endtask

    // Reference model: architectural meaning of each funct, in plain 64-bit arithmetic.
    task automatic model(input logic [5:0] f, input logic [W-1:0] a, input logic [W-1:0] b,
                         output exp_t e, output bit iter);
        longint      sa, sb, r;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        e.o = '0; e.br = (a == b); e.ovf = 1'b0; e.ill = 1'b0; e.due = 0;
        e.has_lit = 1'b0; e.lit_o = '0; e.lit_br = 1'b0; e.lit_ovf = 1'b0; e.lit_ill = 1'b0;
        iter = 1'b0;
        case (f)
            OP_ADD:  begin r = sa + sb; e.o = r[31:0]; e.ovf = (r > SMAX) || (r < SMIN); end
            OP_ADDU: e.o = a + b;
            OP_SUB:  begin r = sa - sb; e.o = r[31:0]; e.ovf = (r > SMAX) || (r < SMIN); end
            OP_SUBU: e.o = a - b;
            OP_AND:  e.o = a & b;
            OP_OR:   e.o = a | b;
            OP_XOR:  e.o = a ^ b;
            OP_NOR:  e.o = ~(a | b);
            OP_SLT:  e.o = (sa < sb) ? 32'd1 : 32'd0;
            OP_SLTU: e.o = (a < b) ? 32'd1 : 32'd0;
            OP_SLL:  e.o = b << a[4:0];
            OP_SRL:  e.o = b >> a[4:0];
            OP_SRA:  begin r = sb >>> a[4:0]; e.o = r[31:0]; end
            OP_MFHI: e.o = m_hi;
            OP_MFLO: e.o = m_lo;
            OP_MULT: begin r = sa * sb; {m_hi, m_lo} = r; e.o = m_lo; iter = 1'b1; end
            OP_MULTU: begin p = {32'd0, a} * {32'd0, b}; {m_hi, m_lo} = p; e.o = m_lo; iter = 1'b1; end
`ifdef ALU_SEQ_DIVIDE_EN
            OP_DIV: begin
                if (b == '0) begin m_hi = a; m_lo = '1; end
                else begin r = sa / sb; m_lo = r[31:0]; r = sa % sb; m_hi = r[31:0]; end
                e.o = m_lo; iter = 1'b1;
            end
            OP_DIVU: begin
                if (b == '0) begin m_hi = a; m_lo = '1; end
                else begin m_lo = a / b; m_hi = a % b; end
                e.o = m_lo; iter = 1'b1;
            end
`endif
            default: e.ill = 1'b1;
        endcase
    endtask

    task automatic model_reset();
        q.delete();
        busy_lo = 1;
        busy_hi = 0;
        m_hi    = '0;
        m_lo    = '0;
    endtask

    // Offers one op (called just after a falling edge), waits for acceptance, records the expectation.
    task automatic issue(input logic [5:0] f, input logic [W-1:0] a, input logic [W-1:0] b,
                         input bit has_lit, input logic [W-1:0] lo, input logic lbr,
                         input logic lovf, input logic lill);
        exp_t e;
        bit   iter;
        int   guard;
        in_valid = 1'b1;
        Func_in  = f;
        A_in     = a;
        B_in     = b;
        guard    = 0;
        while (in_ready !== 1'b1 && guard < 200) begin
            wait_neg();
            guard++;
        end
        if (guard >= 200) check("accept_timeout", in_ready, 1);
        model(f, a, b, e, iter);
        e.due = cyc + 1 + (iter ? W : 0);
        if (iter) begin
            busy_lo = cyc + 1;
            busy_hi = cyc + W;
        end
        if (has_lit) begin
            e.has_lit = 1'b1; e.lit_o = lo; e.lit_br = lbr; e.lit_ovf = lovf; e.lit_ill = lill;
            check("model_O", e.o, lo);
            check("model_br", e.br, lbr);
            check("model_ovf", e.ovf, lovf);
            check("model_ill", e.ill, lill);
        end
        q.push_back(e);
        wait_neg();
        in_valid = 1'b0;
    endtask

    // Per-cycle comparison of DUT outputs against the model's expectation queue.
    always @(negedge ref_clk) begin
        if (reset === 1'b1) begin
            check("in_ready", in_ready, !(cyc >= busy_lo && cyc <= busy_hi));
            if (q.size() > 0 && q[0].due == cyc) begin
                ce = q.pop_front();
                check("out_valid", out_valid, 1);
                check("O_out", O_out, ce.o);
                check("Branch_out", Branch_out, ce.br);
                check("ovf_out", ovf_out, ce.ovf);
                check("illegal_out", illegal_out, ce.ill);
                if (ce.has_lit) begin
                    check("lit_O_out", O_out, ce.lit_o);
                    check("lit_Branch_out", Branch_out, ce.lit_br);
                    check("lit_ovf_out", ovf_out, ce.lit_ovf);
                    check("lit_illegal_out", illegal_out, ce.lit_ill);
                end
            end else begin
                check("out_valid_idle", out_valid, 0);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset    = 1'b0;
        in_valid = 1'b0;
        Func_in  = '0;
        A_in     = '0;
        B_in     = '0;
        repeat (3) @(negedge ref_clk);
        check("rst_O_out", O_out, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_Branch_out", Branch_out, 0);
        check("rst_ovf_out", ovf_out, 0);
        check("rst_illegal_out", illegal_out, 0);
        #1 reset = 1'b1;
        wait_neg();

        issue(OP_ADDU, 32'd1, 32'd3, 1, 32'd4, 0, 0, 0);
        issue(OP_ADD, 32'h7FFFFFFF, 32'd1, 1, 32'h80000000, 0, 1, 0);
        issue(OP_SUB, 32'd5, 32'd5, 1, 32'd0, 1, 0, 0);
        issue(OP_SUB, 32'h80000000, 32'd1, 1, 32'h7FFFFFFF, 0, 1, 0);
        issue(OP_ADDU, 32'h7FFFFFFF, 32'd1, 1, 32'h80000000, 0, 0, 0);
        issue(OP_SUBU, 32'd0, 32'd1, 1, 32'hFFFFFFFF, 0, 0, 0);
        issue(OP_SRA, 32'd4, 32'h80000000, 1, 32'hF8000000, 0, 0, 0);
        issue(OP_SLTU, 32'd1, 32'hFFFFFFFF, 1, 32'd1, 0, 0, 0);
        issue(OP_SLT, 32'd1, 32'hFFFFFFFF, 1, 32'd0, 0, 0, 0);
        issue(OP_AND, 32'hF0F0F0F0, 32'hFF00FF00, 1, 32'hF000F000, 0, 0, 0);
        issue(OP_OR, 32'h0000F0F0, 32'h00FF0000, 0, '0, 0, 0, 0);
        issue(OP_XOR, 32'hAAAA5555, 32'hFFFF0000, 0, '0, 0, 0, 0);
        issue(OP_NOR, 32'd0, 32'd0, 1, 32'hFFFFFFFF, 1, 0, 0);
        issue(OP_SLL, 32'h0000001F, 32'd1, 1, 32'h80000000, 0, 0, 0);
        issue(OP_SRL, 32'h00000024, 32'h80000000, 1, 32'h08000000, 0, 0, 0);

        issue(OP_MULT, 32'hFFFFFFFD, 32'd7, 1, 32'hFFFFFFEB, 0, 0, 0);
        issue(OP_MFHI, 32'd0, 32'd0, 1, 32'hFFFFFFFF, 1, 0, 0);
        issue(OP_MFLO, 32'd0, 32'd1, 1, 32'hFFFFFFEB, 0, 0, 0);
        issue(OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 1, 32'h00000001, 1, 0, 0);
        issue(OP_MFHI, 32'd0, 32'd1, 1, 32'hFFFFFFFE, 0, 0, 0);
`ifdef ALU_SEQ_DIVIDE_EN
        issue(OP_DIV, 32'hFFFFFFF9, 32'd2, 1, 32'hFFFFFFFD, 0, 0, 0);
        issue(OP_MFHI, 32'd0, 32'd1, 1, 32'hFFFFFFFF, 0, 0, 0);
        issue(OP_DIVU, 32'd9, 32'd0, 1, 32'hFFFFFFFF, 0, 0, 0);
        issue(OP_MFHI, 32'd0, 32'd1, 1, 32'd9, 0, 0, 0);
        issue(OP_DIV, 32'h80000000, 32'hFFFFFFFF, 0, '0, 0, 0, 0);
        issue(OP_MFHI, 32'd0, 32'd1, 0, '0, 0, 0, 0);
        issue(OP_DIV, 32'd100, 32'hFFFFFFF9, 0, '0, 0, 0, 0);
        issue(OP_MFHI, 32'd0, 32'd1, 0, '0, 0, 0, 0);
`else
        issue(OP_DIV, 32'hFFFFFFF9, 32'd2, 1, 32'd0, 0, 0, 1);
        issue(OP_MFHI, 32'd0, 32'd1, 1, 32'hFFFFFFFE, 0, 0, 0);
        issue(OP_DIVU, 32'd9, 32'd0, 1, 32'd0, 0, 0, 1);
        issue(OP_MFLO, 32'd0, 32'd1, 1, 32'h00000001, 0, 0, 0);
`endif
        issue(OP_ADDU, 32'd2, 32'd2, 0, '0, 0, 0, 0);

        issue(OP_MULTU, 32'h12345678, 32'h9ABCDEF0, 0, '0, 0, 0, 0);
        repeat (10) wait_neg();
        reset = 1'b0;
        model_reset();
        #1;
        check("async_rst_O_out", O_out, 0);
        check("async_rst_out_valid", out_valid, 0);
        repeat (2) wait_neg();
        reset = 1'b1;
        wait_neg();
        issue(OP_MFHI, 32'd0, 32'd1, 1, 32'd0, 0, 0, 0);
        issue(OP_MFLO, 32'd0, 32'd1, 1, 32'd0, 0, 0, 0);
        issue(6'b111111, 32'd1, 32'd2, 1, 32'd0, 0, 0, 1);
        issue(OP_ADD, 32'h80000000, 32'h80000000, 1, 32'd0, 1, 1, 0);

        repeat (W + 8) wait_neg();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
